ctrl_pipe: RTL and testbench
============================

Name: ctrl_pipe

Overview:
- Consumer end of the decode-stage control unit.
- Takes the EX/M/WB control bundle produced in ID and carries it, with the destination-register tag, through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards and inserts bubbles.
- Squashes in-flight instructions when a branch is taken in MEM.
- Keeps retire and bubble counters.

Parameters:
- CNT_W, 16, width of the retire and bubble counters (saturating).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- valid_in  in  1  ID holds a real instruction
- ex_in  in  4  {RegDst, ALUOp[1:0], ALUSrc} from control
- m_in  in  3  {Branch, MemRead, MemWrite} from control
- wb_in  in  2  {RegWrite, MemtoReg} from control
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_rd  in  5  rd field of the instruction in ID
- br_taken  in  1  branch condition true for the instruction in MEM
- stall  out  1  combinational; holds PC and IF/ID when high
- ex_idex  out  4  ID/EX EX bundle
- idex_valid  out  1  ID/EX holds a real instruction
- m_exmem  out  3  EX/MEM M bundle
- exmem_valid  out  1  EX/MEM holds a real instruction
- flush  out  1  combinational; accepted branch flush
- wb_memwb  out  2  MEM/WB WB bundle
- memwb_dst  out  5  MEM/WB write-back register
- memwb_valid  out  1  MEM/WB holds a real instruction
- retired  out  CNT_W  count of instructions leaving MEM/WB
- bubbles  out  CNT_W  count of bubbles inserted

Behaviour:
- Synchronous reset (rst_n=0 at a clock edge) clears all stage registers, valids, dst tags, bundles and both counters. stall=0 and flush=0 while the registers hold reset values.
- A mid-operation reset discards everything in flight. No partial retire is counted for that edge.
- Bubble: all bundle bits 0, valid 0, dst 0.
- Latency, for a bundle in ID at edge n with no stall or flush:
  - EX bits appear on ex_idex after edge n.
  - M bits appear on m_exmem after edge n+1.
  - WB bits appear on wb_memwb after edge n+2.
- Destination tag: at the ID/EX→EX/MEM transfer, dst = RegDst ? rd : rt, using the rt/rd values latched in ID/EX.
- stall = valid_in & idex_valid & idex_M.MemRead & (idex_rt != 0) & (idex_rt == id_rs | idex_rt == id_rt).
- flush = br_taken & exmem_valid & exmem_M.Branch. br_taken is ignored otherwise.
- Priority at each edge (flush beats stall):
  - flush=1: ID/EX ← bubble, EX/MEM ← bubble, MEM/WB ← EX/MEM (the branch itself advances), bubbles += 1.
  - else stall=1: ID/EX ← bubble, EX/MEM ← ID/EX, MEM/WB ← EX/MEM, bubbles += 1. The upstream unit keeps ID constant.
  - else: normal shift. ID/EX ← inputs with valid = valid_in; a bundle with valid_in=0 is loaded as a bubble.
- retired increments on every edge where memwb_valid=1 and reset is inactive.
- Both counters saturate at 2^CNT_W−1 and do not wrap.
- stall and flush are purely combinational from current state and inputs. No registered outputs depend on the same-cycle stall.

Test Plan:
- Reset then idle with valid_in=0 → all outputs 0, retired=0, bubbles=0 for 10 cycles.
- R-type: ex_in=1100, m_in=000, wb_in=10, rd=5, rt=3, one cycle →
  - ex_idex=1100 at +1
  - m_exmem=000 at +2
  - wb_memwb=10 and memwb_dst=5 at +3
  - retired=1 at +4.
- lw: ex=0001, m=010, wb=11, rt=8, followed by an R-type with rs=8 →
  - stall=1 for exactly one cycle
  - ex_idex=0000 and idex_valid=0 for one cycle
  - bubbles=1
  - R-type reaches MEM/WB one cycle late
  - repeat with rt=0 → no stall.
- beq: ex=0010, m=100, wb=00, followed by two R-types; br_taken=1 while beq is in EX/MEM →
  - flush=1 for one cycle
  - both R-types squashed
  - retired counts the beq only
  - bubbles=1.
- br_taken=1 while EX/MEM holds an lw (Branch=0) → flush=0 and the pipeline is unaffected. Load-use stall and flush in the same cycle → flush behaviour, bubbles += 1 only.
- Assert rst_n=0 for one edge with three instructions in flight → all stages empty next cycle, counters 0, no retire is counted afterward for the discarded instructions. Separately, CNT_W=4 with 20 retires → retired holds at 15.

Source files
------------

// File: rtl/ctrl_pipe.sv
// Control-bundle pipeline from ID/EX through MEM/WB. It detects load-use hazards,
// squashes wrong-path instructions on a taken branch, and counts retires and bubbles.
module ctrl_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [3:0]       ex_in,
  input  logic [2:0]       m_in,
  input  logic [1:0]       wb_in,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             br_taken,
  output logic             stall,
  output logic [3:0]       ex_idex,
  output logic             idex_valid,
  output logic [2:0]       m_exmem,
  output logic             exmem_valid,
  output logic             flush,
  output logic [1:0]       wb_memwb,
  output logic [4:0]       memwb_dst,
  output logic             memwb_valid,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] bubbles
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_idex_valid;
  logic [3:0]       r_idex_ex;
  logic [2:0]       r_idex_m;
  logic [1:0]       r_idex_wb;
  logic [4:0]       r_idex_rt;
  logic [4:0]       r_idex_rd;
  logic             r_exmem_valid;
  logic [2:0]       r_exmem_m;
  logic [1:0]       r_exmem_wb;
  logic [4:0]       r_exmem_dst;
  logic             r_memwb_valid;
  logic [1:0]       r_memwb_wb;
  logic [4:0]       r_memwb_dst;
  logic [CNT_W-1:0] r_retired;
  logic [CNT_W-1:0] r_bubbles;

  logic             w_stall;
  logic             w_flush;
  logic [4:0]       w_idex_dst;

  // ID/EX MemRead is m[1]; EX/MEM Branch is m[2]; RegDst is ex[3].
  assign w_stall = valid_in & r_idex_valid & r_idex_m[1] & (r_idex_rt != 5'd0) &
                   ((r_idex_rt == id_rs) | (r_idex_rt == id_rt));
  assign w_flush = br_taken & r_exmem_valid & r_exmem_m[2];
  assign w_idex_dst = r_idex_ex[3] ? r_idex_rd : r_idex_rt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idex_valid  <= 1'b0;
      r_idex_ex     <= '0;
      r_idex_m      <= '0;
      r_idex_wb     <= '0;
      r_idex_rt     <= '0;
      r_idex_rd     <= '0;
      r_exmem_valid <= 1'b0;
      r_exmem_m     <= '0;
      r_exmem_wb    <= '0;
      r_exmem_dst   <= '0;
      r_memwb_valid <= 1'b0;
      r_memwb_wb    <= '0;
      r_memwb_dst   <= '0;
      r_retired     <= '0;
      r_bubbles     <= '0;
    end else begin
      // The instruction in EX/MEM always advances, including a branch that flushes.
      r_memwb_valid <= r_exmem_valid;
      r_memwb_wb    <= r_exmem_wb;
      r_memwb_dst   <= r_exmem_dst;

      if (w_flush) begin
        r_exmem_valid <= 1'b0;
        r_exmem_m     <= '0;
        r_exmem_wb    <= '0;
        r_exmem_dst   <= '0;
      end else begin
        r_exmem_valid <= r_idex_valid;
        r_exmem_m     <= r_idex_m;
        r_exmem_wb    <= r_idex_wb;
        r_exmem_dst   <= w_idex_dst;
      end

      if (w_flush || w_stall || !valid_in) begin
        r_idex_valid <= 1'b0;
        r_idex_ex    <= '0;
        r_idex_m     <= '0;
        r_idex_wb    <= '0;
        r_idex_rt    <= '0;
        r_idex_rd    <= '0;
      end else begin
        r_idex_valid <= 1'b1;
        r_idex_ex    <= ex_in;
        r_idex_m     <= m_in;
        r_idex_wb    <= wb_in;
        r_idex_rt    <= id_rt;
        r_idex_rd    <= id_rd;
      end

      if (r_memwb_valid && (r_retired != '1)) r_retired <= r_retired + CNT_ONE;
      if ((w_flush || w_stall) && (r_bubbles != '1)) r_bubbles <= r_bubbles + CNT_ONE;
    end
  end

  assign stall       = w_stall;
  assign flush       = w_flush;
  assign ex_idex     = r_idex_ex;
  assign idex_valid  = r_idex_valid;
  assign m_exmem     = r_exmem_m;
  assign exmem_valid = r_exmem_valid;
  assign wb_memwb    = r_memwb_wb;
  assign memwb_dst   = r_memwb_dst;
  assign memwb_valid = r_memwb_valid;
  assign retired     = r_retired;
  assign bubbles     = r_bubbles;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: directed scenarios followed by random instruction streams,
// checked every cycle against an instruction-level model of the pipeline.
module tb_ctrl_pipe;

  logic       clk;
  logic       rst_n;
  logic       valid_in;
  logic [3:0] ex_in;
  logic [2:0] m_in;
  logic [1:0] wb_in;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       br_taken;

  logic        stall, flush, idex_valid, exmem_valid, memwb_valid;
  logic [3:0]  ex_idex;
  logic [2:0]  m_exmem;
  logic [1:0]  wb_memwb;
  logic [4:0]  memwb_dst;
  logic [15:0] retired, bubbles;

  logic        s_stall, s_flush, s_idex_valid, s_exmem_valid, s_memwb_valid;
  logic [3:0]  s_ex_idex;
  logic [2:0]  s_m_exmem;
  logic [1:0]  s_wb_memwb;
  logic [4:0]  s_memwb_dst;
  logic [3:0]  s_retired, s_bubbles;

  int vectors = 0;
  int miscompares = 0;

  ctrl_pipe #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ex_in(ex_in), .m_in(m_in),
    .wb_in(wb_in), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .br_taken(br_taken),
    .stall(stall), .ex_idex(ex_idex), .idex_valid(idex_valid), .m_exmem(m_exmem),
    .exmem_valid(exmem_valid), .flush(flush), .wb_memwb(wb_memwb), .memwb_dst(memwb_dst),
    .memwb_valid(memwb_valid), .retired(retired), .bubbles(bubbles)
  );

  ctrl_pipe #(.CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ex_in(ex_in), .m_in(m_in),
    .wb_in(wb_in), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .br_taken(br_taken),
    .stall(s_stall), .ex_idex(s_ex_idex), .idex_valid(s_idex_valid), .m_exmem(s_m_exmem),
    .exmem_valid(s_exmem_valid), .flush(s_flush), .wb_memwb(s_wb_memwb),
    .memwb_dst(s_memwb_dst), .memwb_valid(s_memwb_valid), .retired(s_retired),
    .bubbles(s_bubbles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One in-flight instruction; a zero record is an empty slot.
  typedef struct packed {
    logic       v;
    logic [3:0] ex;
    logic [2:0] m;
    logic [1:0] wb;
    logic [4:0] rs, rt, rd;
  } instr_t;

  instr_t in_ex, in_mem, in_wb;
  int     n_retired, n_bubbles;

  function automatic int sat(input int n, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (n > lim) ? lim : n;
  endfunction

  function automatic logic model_stall();
    return valid_in && in_ex.v && in_ex.m[1] && in_ex.rt != 0 &&
           (in_ex.rt == id_rs || in_ex.rt == id_rt);
  endfunction

  function automatic logic model_flush();
    return br_taken && in_mem.v && in_mem.m[2];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_in(input logic v, input logic [3:0] ex, input logic [2:0] m,
                        input logic [1:0] wb, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic br);
    valid_in = v; ex_in = ex; m_in = m; wb_in = wb;
    id_rs = rs; id_rt = rt; id_rd = rd; br_taken = br;
  endtask

  // Check all outputs mid-cycle, advance the model, then cross the edge.
  task automatic tick();
    logic   st, fl;
    instr_t cur;
    #1;
    st = model_stall();
    fl = model_flush();
    chk("stall", stall, st);
    chk("flush", flush, fl);
    chk("ex_idex", ex_idex, in_ex.ex);
    chk("idex_valid", idex_valid, in_ex.v);
    chk("m_exmem", m_exmem, in_mem.m);
    chk("exmem_valid", exmem_valid, in_mem.v);
    chk("wb_memwb", wb_memwb, in_wb.wb);
    chk("memwb_dst", memwb_dst, in_wb.v ? (in_wb.ex[3] ? in_wb.rd : in_wb.rt) : 5'd0);
    chk("memwb_valid", memwb_valid, in_wb.v);
    chk("retired", retired, sat(n_retired, 16));
    chk("bubbles", bubbles, sat(n_bubbles, 16));
    chk("retired_w4", s_retired, sat(n_retired, 4));
    chk("bubbles_w4", s_bubbles, sat(n_bubbles, 4));
    if (!rst_n) begin
      in_ex = '0; in_mem = '0; in_wb = '0;
      n_retired = 0; n_bubbles = 0;
    end else begin
      if (in_wb.v) n_retired++;
      if (fl || st) n_bubbles++;
      cur = {1'b1, ex_in, m_in, wb_in, id_rs, id_rt, id_rd};
      in_wb = in_mem;
      if (fl) begin
        in_mem = '0;
        in_ex  = '0;
      end else begin
        in_mem = in_ex;
        in_ex  = (st || !valid_in) ? instr_t'('0) : cur;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(1'b0, 4'h0, 3'h0, 2'h0, 5'd0, 5'd0, 5'd0, 1'b0);
      tick();
    end
  endtask

  initial begin
    logic       hold;
    int         kind;
    logic [4:0] rs, rt, rd;
    in_ex = '0; in_mem = '0; in_wb = '0;
    n_retired = 0; n_bubbles = 0;
    rst_n = 1'b0;
    set_in(1'b0, 4'h0, 3'h0, 2'h0, 5'd0, 5'd0, 5'd0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    idle(10);

    // R-type rd=5 rt=3 flowing through all stages.
    set_in(1'b1, 4'b1100, 3'b000, 2'b10, 5'd1, 5'd3, 5'd5, 1'b0); tick();
    idle(5);

    // lw r8 then dependent R-type: one stall cycle with ID held.
    set_in(1'b1, 4'b0001, 3'b010, 2'b11, 5'd2, 5'd8, 5'd0, 1'b0); tick();
    set_in(1'b1, 4'b1100, 3'b000, 2'b10, 5'd8, 5'd4, 5'd9, 1'b0); tick(); tick();
    idle(5);

    // lw targeting r0 never stalls.
    set_in(1'b1, 4'b0001, 3'b010, 2'b11, 5'd2, 5'd0, 5'd0, 1'b0); tick();
    set_in(1'b1, 4'b1100, 3'b000, 2'b10, 5'd0, 5'd0, 5'd9, 1'b0); tick();
    idle(5);

    // Taken beq squashes the two R-types behind it.
    set_in(1'b1, 4'b0010, 3'b100, 2'b00, 5'd1, 5'd2, 5'd0, 1'b0); tick();
    set_in(1'b1, 4'b1100, 3'b000, 2'b10, 5'd3, 5'd4, 5'd6, 1'b0); tick();
    set_in(1'b1, 4'b1100, 3'b000, 2'b10, 5'd3, 5'd4, 5'd7, 1'b1); tick();
    idle(5);

    // br_taken with an lw in EX/MEM has no effect.
    set_in(1'b1, 4'b0001, 3'b010, 2'b11, 5'd1, 5'd10, 5'd0, 1'b0); tick();
    set_in(1'b1, 4'b1100, 3'b000, 2'b10, 5'd3, 5'd4, 5'd11, 1'b0); tick();
    set_in(1'b1, 4'b1100, 3'b000, 2'b10, 5'd3, 5'd4, 5'd12, 1'b1); tick();
    idle(5);

    // Stall and flush in the same cycle: flush wins, one bubble.
    set_in(1'b1, 4'b0010, 3'b100, 2'b00, 5'd1, 5'd2, 5'd0, 1'b0); tick();
    set_in(1'b1, 4'b0001, 3'b010, 2'b11, 5'd1, 5'd2, 5'd0, 1'b0); tick();
    set_in(1'b1, 4'b1100, 3'b000, 2'b10, 5'd2, 5'd5, 5'd13, 1'b1); tick();
    idle(5);

    // Reset with three instructions in flight.
    set_in(1'b1, 4'b1100, 3'b000, 2'b10, 5'd1, 5'd2, 5'd14, 1'b0); tick();
    set_in(1'b1, 4'b0001, 3'b001, 2'b00, 5'd1, 5'd2, 5'd0, 1'b0); tick();
    set_in(1'b1, 4'b1100, 3'b000, 2'b10, 5'd1, 5'd2, 5'd15, 1'b0); tick();
    set_in(1'b0, 4'h0, 3'h0, 2'h0, 5'd0, 5'd0, 5'd0, 1'b0);
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    idle(5);

    // Random instruction mix; small register range makes hazards common.
    hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        kind = $urandom_range(0, 4);
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 31));
        case (kind)
          0: set_in(1'b0, 4'($urandom), 3'($urandom), 2'($urandom), rs, rt, rd, 1'b0);
          1: set_in(1'b1, 4'b1100, 3'b000, 2'b10, rs, rt, rd, 1'b0);
          2: set_in(1'b1, 4'b0001, 3'b010, 2'b11, rs, rt, rd, 1'b0);
          3: set_in(1'b1, 4'b0001, 3'b001, 2'b00, rs, rt, rd, 1'b0);
          default: set_in(1'b1, 4'b0010, 3'b100, 2'b00, rs, rt, rd, 1'b0);
        endcase
      end
      br_taken = 1'($urandom_range(0, 1));
      #1;
      hold = model_stall() && !model_flush();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
